// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game input stage: FSM state codes
// (also shown on the hex display) and default sizing constants.
package jogo_pkg;

  // Default number of consecutive synchronized samples a key value must hold
  localparam int CICLOS_ESTAVEL_PADRAO = 2;

  // Default number of keys on the board
  localparam int N_CHAVES_PADRAO = 4;

  // Detector states; the encoding is what db_estado shows on the display
  typedef enum logic [3:0] {
    ESPERA   = 4'h0,
    FILTRA   = 4'h1,
    REGISTRA = 4'h2,
    SOLTA    = 4'h3
  } estado_t;

endpackage

// File: rtl/sincronizador_chaves.sv
// Two-flop synchronizer for the raw key inputs. Only the second flop's
// output may be used by downstream logic.
module sincronizador_chaves #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] i_chaves,
  output logic [LARGURA-1:0] o_chaves
);

  logic [LARGURA-1:0] r_meta;
  logic [LARGURA-1:0] r_sinc;

  // Shift the asynchronous keys through two flops; both clear on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_sinc <= '0;
    end else begin
      r_meta <= i_chaves;
      r_sinc <= r_meta;
    end
  end

  assign o_chaves = r_sinc;

endmodule

// File: rtl/detector_jogada.sv
// Play detector: synchronizes and debounces the keys, accepts a press only
// when exactly one key is held stable, emits one strobe per press and then
// waits for a debounced release before arming again.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int CICLOS_ESTAVEL = CICLOS_ESTAVEL_PADRAO,
  parameter int N_CHAVES       = N_CHAVES_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic                limpa,
  input  logic [N_CHAVES-1:0] chaves,
  output logic [N_CHAVES-1:0] jogada,
  output logic                tem_jogada,
  output logic                jogada_invalida,
  output logic                ocupado,
  output logic [3:0]          db_estado
);

  localparam int W_CNT = $clog2(CICLOS_ESTAVEL + 1);
  localparam logic [W_CNT-1:0]    CNT_ALVO  = W_CNT'(CICLOS_ESTAVEL);
  localparam logic [W_CNT-1:0]    CNT_SOLTA = W_CNT'(CICLOS_ESTAVEL - 1);
  localparam logic [W_CNT-1:0]    CNT_UM    = W_CNT'(1);
  localparam logic [N_CHAVES-1:0] CHAVE_UM  = N_CHAVES'(1);

  estado_t             r_estado;
  logic [N_CHAVES-1:0] r_amostra;
  logic [W_CNT-1:0]    r_cnt;
  logic [N_CHAVES-1:0] r_jogada;
  logic                r_tem_jogada;
  logic                r_jogada_invalida;

  logic [N_CHAVES-1:0] w_s;
  logic                w_um_ativo;
  logic [W_CNT-1:0]    w_cnt_inc;

  sincronizador_chaves #(
    .LARGURA (N_CHAVES)
  ) u_sincronizador (
    .clock    (clock),
    .reset    (reset),
    .i_chaves (chaves),
    .o_chaves (w_s)
  );

  // A nonzero value with no bit shared with (value - 1) has exactly one bit set
  assign w_um_ativo = (r_amostra != '0) && ((r_amostra & (r_amostra - CHAVE_UM)) == '0);

  // The counter holds at its maximum instead of wrapping
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_UM;

  // Detector FSM with the stability counter, candidate sample, play register
  // and registered strobes; the strobes are only ever high while in REGISTRA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado          <= ESPERA;
      r_amostra         <= '0;
      r_cnt             <= '0;
      r_jogada          <= '0;
      r_tem_jogada      <= 1'b0;
      r_jogada_invalida <= 1'b0;
    end else begin
      r_tem_jogada      <= 1'b0;
      r_jogada_invalida <= 1'b0;
      if (limpa) begin
        r_jogada <= '0;
      end
      case (r_estado)
        ESPERA: begin
          if (habilita && (w_s != '0)) begin
            r_estado  <= FILTRA;
            r_amostra <= w_s;
            r_cnt     <= CNT_UM;
          end
        end
        FILTRA: begin
          if (!habilita) begin
            r_estado <= ESPERA;
          end else if (w_s == '0) begin
            r_estado <= ESPERA;
          end else if (w_s != r_amostra) begin
            r_amostra <= w_s;
            r_cnt     <= CNT_UM;
          end else if (r_cnt == CNT_ALVO) begin
            r_estado          <= REGISTRA;
            r_tem_jogada      <= w_um_ativo;
            r_jogada_invalida <= !w_um_ativo;
            if (w_um_ativo) begin
              r_jogada <= r_amostra;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        REGISTRA: begin
          r_estado <= SOLTA;
          r_cnt    <= '0;
          if (r_tem_jogada) begin
            r_jogada <= r_amostra;
          end
        end
        SOLTA: begin
          if (w_s != '0) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_SOLTA) begin
            r_estado <= ESPERA;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_estado <= ESPERA;
        end
      endcase
    end
  end

  assign jogada          = r_jogada;
  assign tem_jogada      = r_tem_jogada;
  assign jogada_invalida = r_jogada_invalida;
  assign ocupado         = (r_estado != ESPERA);
  assign db_estado       = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with the default sizing (2 stable
// samples, 4 keys). Expected values are worked out by hand from the
// synchronizer + FSM timing.
`timescale 1ns/1ps
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic       limpa;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic       ocupado;
  logic [3:0] db_estado;

  int nComparados = 0;
  int nFalhas     = 0;
  int nTem        = 0;
  int nInv        = 0;

  detector_jogada #(
    .CICLOS_ESTAVEL (2),
    .N_CHAVES       (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .limpa           (limpa),
    .chaves          (chaves),
    .jogada          (jogada),
    .tem_jogada      (tem_jogada),
    .jogada_invalida (jogada_invalida),
    .ocupado         (ocupado),
    .db_estado       (db_estado)
  );

  // 100 MHz bench clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count strobe cycles in the middle of each cycle, away from the edge
  always @(negedge clock) begin
    if (tem_jogada) nTem++;
    if (jogada_invalida) nInv++;
  end

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; habilita = 1'b0; limpa = 1'b0; chaves = 4'b0000;
    #12;
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL reset_estado: got %h expected %h", db_estado, 4'h0); end
    nComparados++;
    if (jogada !== 4'b0000) begin nFalhas++; $display("[TB] FAIL reset_jogada: got %b expected %b", jogada, 4'b0000); end
    nComparados++;
    if ({tem_jogada, jogada_invalida, ocupado} !== 3'b000) begin nFalhas++; $display("[TB] FAIL reset_strobes: got %b expected %b", {tem_jogada, jogada_invalida, ocupado}, 3'b000); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_basico;
    int t0;
    t0 = nTem;
    habilita = 1'b1;
    chaves = 4'b0001;
    tick(3);
    chaves = 4'b0000;
    tick(1);
    nComparados++;
    if (db_estado !== 4'h1 || tem_jogada !== 1'b0) begin nFalhas++; $display("[TB] FAIL basico_filtra: got estado=%h tem=%b expected estado=1 tem=0", db_estado, tem_jogada); end
    tick(1);
    nComparados++;
    if (tem_jogada !== 1'b1) begin nFalhas++; $display("[TB] FAIL basico_tem: got %b expected 1", tem_jogada); end
    nComparados++;
    if (jogada !== 4'b0001) begin nFalhas++; $display("[TB] FAIL basico_jogada: got %b expected 0001", jogada); end
    nComparados++;
    if (db_estado !== 4'h2 || ocupado !== 1'b1) begin nFalhas++; $display("[TB] FAIL basico_registra: got estado=%h ocupado=%b expected estado=2 ocupado=1", db_estado, ocupado); end
    tick(1);
    nComparados++;
    if (db_estado !== 4'h3 || tem_jogada !== 1'b0) begin nFalhas++; $display("[TB] FAIL basico_solta: got estado=%h tem=%b expected estado=3 tem=0", db_estado, tem_jogada); end
    tick(1);
    nComparados++;
    if (db_estado !== 4'h3) begin nFalhas++; $display("[TB] FAIL basico_solta_conta: got %h expected 3", db_estado); end
    tick(1);
    nComparados++;
    if (db_estado !== 4'h0 || ocupado !== 1'b0) begin nFalhas++; $display("[TB] FAIL basico_espera: got estado=%h ocupado=%b expected estado=0 ocupado=0", db_estado, ocupado); end
    nComparados++;
    if (nTem - t0 !== 1) begin nFalhas++; $display("[TB] FAIL basico_pulsos: got %0d expected 1", nTem - t0); end
  endtask

  task automatic test_pressao_longa;
    int t0;
    int i0;
    t0 = nTem; i0 = nInv;
    chaves = 4'b0100;
    tick(200);
    nComparados++;
    if (nTem - t0 !== 1) begin nFalhas++; $display("[TB] FAIL longa_pulsos: got %0d expected 1", nTem - t0); end
    nComparados++;
    if (jogada !== 4'b0100 || db_estado !== 4'h3) begin nFalhas++; $display("[TB] FAIL longa_jogada: got jogada=%b estado=%h expected jogada=0100 estado=3", jogada, db_estado); end
    nComparados++;
    if (nInv - i0 !== 0) begin nFalhas++; $display("[TB] FAIL longa_invalida: got %0d expected 0", nInv - i0); end
    chaves = 4'b0000;
    tick(3);
    nComparados++;
    if (db_estado !== 4'h3) begin nFalhas++; $display("[TB] FAIL longa_solta_curta: got %h expected 3", db_estado); end
    tick(1);
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL longa_espera: got %h expected 0", db_estado); end
    chaves = 4'b0010;
    tick(5);
    nComparados++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0010) begin nFalhas++; $display("[TB] FAIL longa_segunda: got tem=%b jogada=%b expected tem=1 jogada=0010", tem_jogada, jogada); end
    chaves = 4'b0000;
    tick(4);
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL longa_segunda_espera: got %h expected 0", db_estado); end
  endtask

  task automatic test_invalida;
    int t0;
    int i0;
    t0 = nTem; i0 = nInv;
    chaves = 4'b0011;
    tick(4);
    chaves = 4'b0000;
    tick(1);
    nComparados++;
    if (jogada_invalida !== 1'b1 || tem_jogada !== 1'b0) begin nFalhas++; $display("[TB] FAIL invalida_strobe: got inv=%b tem=%b expected inv=1 tem=0", jogada_invalida, tem_jogada); end
    nComparados++;
    if (jogada !== 4'b0010 || db_estado !== 4'h2) begin nFalhas++; $display("[TB] FAIL invalida_mantem: got jogada=%b estado=%h expected jogada=0010 estado=2", jogada, db_estado); end
    tick(3);
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL invalida_espera: got %h expected 0", db_estado); end
    nComparados++;
    if (nInv - i0 !== 1 || nTem - t0 !== 0) begin nFalhas++; $display("[TB] FAIL invalida_pulsos: got inv=%0d tem=%0d expected inv=1 tem=0", nInv - i0, nTem - t0); end
  endtask

  task automatic test_glitch;
    int t0;
    int i0;
    int k;
    t0 = nTem; i0 = nInv;
    chaves = 4'b1000;
    tick(1);
    chaves = 4'b0000;
    tick(2);
    nComparados++;
    if (db_estado !== 4'h1) begin nFalhas++; $display("[TB] FAIL glitch_filtra: got %h expected 1", db_estado); end
    tick(1);
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL glitch_rejeita: got %h expected 0", db_estado); end
    for (int i = 0; i < 12; i++) begin
      chaves = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      tick(1);
    end
    nComparados++;
    if (db_estado !== 4'h1) begin nFalhas++; $display("[TB] FAIL alterna_filtra: got %h expected 1", db_estado); end
    chaves = 4'b0000;
    k = 0;
    while (db_estado !== 4'h0 && k < 8) begin
      tick(1);
      k++;
    end
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL alterna_espera: got %h expected 0", db_estado); end
    nComparados++;
    if (nTem - t0 !== 0 || nInv - i0 !== 0) begin nFalhas++; $display("[TB] FAIL alterna_pulsos: got tem=%0d inv=%0d expected 0 0", nTem - t0, nInv - i0); end
  endtask

  task automatic test_habilita;
    int t0;
    t0 = nTem;
    habilita = 1'b0;
    chaves = 4'b0001;
    tick(10);
    nComparados++;
    if (db_estado !== 4'h0 || nTem - t0 !== 0) begin nFalhas++; $display("[TB] FAIL habilita_bloqueia: got estado=%h pulsos=%0d expected estado=0 pulsos=0", db_estado, nTem - t0); end
    habilita = 1'b1;
    tick(2);
    nComparados++;
    if (db_estado !== 4'h1) begin nFalhas++; $display("[TB] FAIL habilita_filtra: got %h expected 1", db_estado); end
    tick(1);
    nComparados++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0001) begin nFalhas++; $display("[TB] FAIL habilita_aceita: got tem=%b jogada=%b expected tem=1 jogada=0001", tem_jogada, jogada); end
    chaves = 4'b0000;
    tick(4);
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL habilita_espera: got %h expected 0", db_estado); end
    t0 = nTem;
    chaves = 4'b0100;
    tick(3);
    nComparados++;
    if (db_estado !== 4'h1) begin nFalhas++; $display("[TB] FAIL aborta_filtra: got %h expected 1", db_estado); end
    habilita = 1'b0;
    tick(1);
    nComparados++;
    if (db_estado !== 4'h0) begin nFalhas++; $display("[TB] FAIL aborta_espera: got %h expected 0", db_estado); end
    tick(5);
    nComparados++;
    if (nTem - t0 !== 0 || jogada !== 4'b0001) begin nFalhas++; $display("[TB] FAIL aborta_sem_strobe: got pulsos=%0d jogada=%b expected 0 0001", nTem - t0, jogada); end
    chaves = 4'b0000;
    tick(3);
    habilita = 1'b1;
  endtask

  task automatic test_reset_meio;
    chaves = 4'b1000;
    tick(3);
    nComparados++;
    if (db_estado !== 4'h1) begin nFalhas++; $display("[TB] FAIL rmeio_filtra: got %h expected 1", db_estado); end
    reset = 1'b0;
    #2;
    nComparados++;
    if (db_estado !== 4'h0 || ocupado !== 1'b0 || jogada !== 4'b0000) begin nFalhas++; $display("[TB] FAIL rmeio_filtra_reset: got estado=%h ocupado=%b jogada=%b expected 0 0 0000", db_estado, ocupado, jogada); end
    nComparados++;
    if (tem_jogada !== 1'b0 || jogada_invalida !== 1'b0) begin nFalhas++; $display("[TB] FAIL rmeio_filtra_strobes: got tem=%b inv=%b expected 0 0", tem_jogada, jogada_invalida); end
    chaves = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(2);
    chaves = 4'b0010;
    tick(5);
    nComparados++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0010) begin nFalhas++; $display("[TB] FAIL rmeio_pre_solta: got tem=%b jogada=%b expected 1 0010", tem_jogada, jogada); end
    tick(1);
    nComparados++;
    if (db_estado !== 4'h3) begin nFalhas++; $display("[TB] FAIL rmeio_solta: got %h expected 3", db_estado); end
    reset = 1'b0;
    #2;
    nComparados++;
    if (db_estado !== 4'h0 || ocupado !== 1'b0 || jogada !== 4'b0000 || tem_jogada !== 1'b0) begin nFalhas++; $display("[TB] FAIL rmeio_solta_reset: got estado=%h ocupado=%b jogada=%b tem=%b expected 0 0 0000 0", db_estado, ocupado, jogada, tem_jogada); end
    chaves = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_limpa;
    int k;
    chaves = 4'b1000;
    tick(5);
    nComparados++;
    if (jogada !== 4'b1000) begin nFalhas++; $display("[TB] FAIL limpa_pre: got %b expected 1000", jogada); end
    chaves = 4'b0000;
    tick(4);
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    nComparados++;
    if (jogada !== 4'b0000) begin nFalhas++; $display("[TB] FAIL limpa_espera: got %b expected 0000", jogada); end
    chaves = 4'b0100;
    tick(4);
    limpa = 1'b1;
    tick(1);
    nComparados++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0100) begin nFalhas++; $display("[TB] FAIL limpa_registra: got tem=%b jogada=%b expected 1 0100", tem_jogada, jogada); end
    tick(1);
    nComparados++;
    if (jogada !== 4'b0100 || db_estado !== 4'h3) begin nFalhas++; $display("[TB] FAIL limpa_vence: got jogada=%b estado=%h expected 0100 3", jogada, db_estado); end
    limpa = 1'b0;
    chaves = 4'b0000;
    k = 0;
    while (db_estado !== 4'h0 && k < 10) begin
      tick(1);
      k++;
    end
    nComparados++;
    if (db_estado !== 4'h0 || jogada !== 4'b0100) begin nFalhas++; $display("[TB] FAIL limpa_final: got estado=%h jogada=%b expected 0 0100", db_estado, jogada); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_basico();
    test_pressao_longa();
    test_invalida();
    test_glitch();
    test_habilita();
    test_reset_meio();
    test_limpa();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComparados, nFalhas);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
